// File: rtl/alu_pkg.sv
// Shared ALU definitions: state encoding and operand/product widths.
package alu_pkg;
  localparam int OPND_W = 2;
  localparam int PROD_W = 4;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;
endpackage

// File: rtl/multiplier2x2.sv
// Combinational 2x2-bit unsigned multiplier; zero latency, no handshake.
module multiplier2x2
  import alu_pkg::*;
(
  input  logic [OPND_W-1:0] A,
  input  logic [OPND_W-1:0] B,
  output logic [PROD_W-1:0] Y
);
  assign Y = {2'b00, A} * {2'b00, B};
endmodule

// File: rtl/dot_product_acc.sv
// Frame multiply-accumulate over LEN operand pairs; sum valid the cycle after the LEN-th accept.
// in_ready drops while a result waits in DONE; out_ready low holds the result indefinitely.
module dot_product_acc
  import alu_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int ACC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] A,
  input  logic [OPND_W-1:0] B,
  input  logic              clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf,
  output logic [3:0]        cnt
);
  state_t             st;
  logic [ACC_W-1:0]   acc;
  logic [PROD_W-1:0]  y;
  logic [ACC_W:0]     add_res;

  multiplier2x2 u_mul (
    .A (A),
    .B (B),
    .Y (y)
  );

  // One extra bit captures the carry-out that feeds the sticky ovf.
  assign add_res = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, y};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      st  <= ST_ACC;
      acc <= '0;
      ovf <= 1'b0;
      cnt <= '0;
    end else begin
      case (st)
        ST_ACC: begin
          if (in_valid) begin
            acc <= add_res[ACC_W-1:0];
            ovf <= ovf | add_res[ACC_W];
            cnt <= cnt + 4'd1;
            if (cnt == 4'(LEN - 1)) st <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            st  <= ST_ACC;
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
          end
        end
        default: st <= ST_ACC;
      endcase
    end
  end

  assign in_ready  = (st == ST_ACC);
  assign out_valid = (st == ST_DONE);
  assign sum       = acc;
endmodule

// File: tb/tb_dot_product_acc.sv
// Directed bench for dot_product_acc: 8-bit and 5-bit accumulator instances, queue scoreboard.
module tb_dot_product_acc;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       sel = 1'b0;
  logic [1:0] A = 2'd0;
  logic [1:0] B = 2'd0;
  logic       clr = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_valid8, in_ready8, out_valid8, ovf8;
  logic [7:0] sum8;
  logic [3:0] cnt8;
  logic       in_valid5, in_ready5, out_valid5, ovf5;
  logic [4:0] sum5;
  logic [3:0] cnt5;

  typedef struct packed {
    logic [7:0] sum;
    logic       ovf;
    logic [3:0] cnt;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  assign in_valid8 = in_valid && !sel;
  assign in_valid5 = in_valid && sel;

  always #5 clk = ~clk;

  dot_product_acc #(.LEN(4), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(A), .B(B), .clr(clr), .out_valid(out_valid8), .out_ready(out_ready),
    .sum(sum8), .ovf(ovf8), .cnt(cnt8)
  );

  dot_product_acc #(.LEN(4), .ACC_W(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5),
    .A(A), .B(B), .clr(clr), .out_valid(out_valid5), .out_ready(out_ready),
    .sum(sum5), .ovf(ovf5), .cnt(cnt5)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every output handshake pops one expected frame result.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid8 && out_ready) begin
        if (q8.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out8_unexpected: got sum %0d, expected no output", sum8);
        end else begin
          exp_t e;
          e = q8.pop_front();
          chk("out8_sum", int'(sum8), int'(e.sum));
          chk("out8_ovf", int'(ovf8), int'(e.ovf));
          chk("out8_cnt", int'(cnt8), int'(e.cnt));
        end
      end
      if (out_valid5 && out_ready) begin
        if (q5.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out5_unexpected: got sum %0d, expected no output", sum5);
        end else begin
          exp_t e;
          e = q5.pop_front();
          chk("out5_sum", int'(sum5), int'(e.sum));
          chk("out5_ovf", int'(ovf5), int'(e.ovf));
          chk("out5_cnt", int'(cnt5), int'(e.cnt));
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one pair to the selected instance, waiting (bounded) for in_ready.
  task automatic pair(input logic [1:0] a, input logic [1:0] b);
    int n;
    n = 0;
    while (!(sel ? in_ready5 : in_ready8) && n < 20) begin
      tick(1);
      n++;
    end
    if (!(sel ? in_ready5 : in_ready8)) chk("in_ready_timeout", 0, 1);
    A = a;
    B = b;
    in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  function automatic exp_t mk(input int s, input int o, input int c);
    exp_t e;
    e.sum = 8'(s);
    e.ovf = 1'(o);
    e.cnt = 4'(c);
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(2);
    rst = 1'b0;
    chk("rst_sum", int'(sum8), 0);
    chk("rst_ovf", int'(ovf8), 0);
    chk("rst_cnt", int'(cnt8), 0);
    chk("rst_out_valid", int'(out_valid8), 0);
    chk("rst_in_ready", int'(in_ready8), 1);
    chk("rst_in_ready5", int'(in_ready5), 1);

    // Basic frame (3,3)x4 = 36
    q8.push_back(mk(36, 0, 4));
    pair(2'd3, 2'd3);
    chk("mid_sum", int'(sum8), 9);
    chk("mid_cnt", int'(cnt8), 1);
    for (int i = 0; i < 3; i++) pair(2'd3, 2'd3);
    chk("basic_out_valid", int'(out_valid8), 1);
    chk("basic_in_ready", int'(in_ready8), 0);
    tick(1);
    chk("basic_one_cycle", int'(out_valid8), 0);
    chk("basic_turnaround", int'(in_ready8), 1);

    // Exhaustive products, one frame per B row
    for (int b = 0; b < 4; b++) begin
      q8.push_back(mk(6 * b, 0, 4));
      for (int a = 0; a < 4; a++) pair(2'(a), 2'(b));
    end
    tick(1);

    // Overflow on the 5-bit instance, then a clean frame
    sel = 1'b1;
    q5.push_back(mk(4, 1, 4));
    for (int i = 0; i < 4; i++) pair(2'd3, 2'd3);
    q5.push_back(mk(4, 0, 4));
    for (int i = 0; i < 4; i++) pair(2'd1, 2'd1);
    tick(1);
    sel = 1'b0;

    // Backpressure: result held, extra in_valid ignored
    out_ready = 1'b0;
    q8.push_back(mk(4, 0, 4));
    for (int i = 0; i < 4; i++) pair(2'd1, 2'd1);
    A = 2'd3;
    B = 2'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("bp_in_ready", int'(in_ready8), 0);
      chk("bp_out_valid", int'(out_valid8), 1);
      chk("bp_sum", int'(sum8), 4);
      chk("bp_cnt", int'(cnt8), 4);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick(1);
    chk("bp_release_in_ready", int'(in_ready8), 1);
    chk("bp_release_sum", int'(sum8), 0);

    // clr mid-frame discards the partial sum and the coincident pair
    pair(2'd2, 2'd3);
    pair(2'd2, 2'd3);
    chk("clr_pre_sum", int'(sum8), 12);
    chk("clr_pre_cnt", int'(cnt8), 2);
    A = 2'd3;
    B = 2'd3;
    in_valid = 1'b1;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_sum", int'(sum8), 0);
    chk("clr_cnt", int'(cnt8), 0);
    chk("clr_in_ready", int'(in_ready8), 1);
    q8.push_back(mk(36, 0, 4));
    for (int i = 0; i < 4; i++) pair(2'd3, 2'd3);
    tick(1);

    // rst while DONE is stalled: result dropped with no handshake
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) pair(2'd1, 2'd2);
    chk("rstd_pre_out_valid", int'(out_valid8), 1);
    chk("rstd_pre_sum", int'(sum8), 8);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rstd_out_valid", int'(out_valid8), 0);
    chk("rstd_sum", int'(sum8), 0);
    chk("rstd_cnt", int'(cnt8), 0);
    chk("rstd_in_ready", int'(in_ready8), 1);
    out_ready = 1'b1;
    tick(3);

    chk("q8_drained", q8.size(), 0);
    chk("q5_drained", q5.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
